// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg: shared DES f-function constants and types.
//   SBOX     : 8 boxes x 4 rows x 16 columns of 4-bit values. Each row is one
//              64-bit word; column 0 is the most significant nibble.
//   P_TABLE  : the 32-entry P permutation. Entries are 1-based DES bit numbers.
//   p_permute: applies P. Bit 31 of a half_t is DES bit 1.
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int NUM_SBOX   = 8;
  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;

  typedef logic [31:0] half_t;
  typedef logic [47:0] exp_t;
  typedef logic [47:0] key48_t;

  localparam logic [0:7][0:3][0:15][3:0] SBOX = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  localparam logic [0:31][5:0] P_TABLE = {
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  // Output DES bit j+1 takes input DES bit P_TABLE[j]. DES bit n maps to vector bit 32-n.
  function automatic half_t p_permute(input half_t din);
    half_t dout;
    dout = 32'h0;
    for (int j = 0; j < 32; j++) begin
      dout[31-j] = din[32 - int'(P_TABLE[j])];
    end
    return dout;
  endfunction

endpackage

// File: rtl/sbox_stage_if.sv
// -----------------------------------------------------------------------------
// sbox_stage_if: valid/ready bundle around sbox_stage.
//   in_valid/in_ready/exp_data/subkey : upstream side from the expansion block
//   out_valid/out_ready/f_out         : downstream side to the round controller
//   slave  : the sbox_stage view
//   master : the view of the surrounding logic that drives both sides
// -----------------------------------------------------------------------------
interface sbox_stage_if;
  import des_pkg::*;

  logic   in_valid;
  logic   in_ready;
  exp_t   exp_data;
  key48_t subkey;
  logic   out_valid;
  logic   out_ready;
  half_t  f_out;

  modport slave (
    input  in_valid, exp_data, subkey, out_ready,
    output in_ready, out_valid, f_out
  );

  modport master (
    output in_valid, exp_data, subkey, out_ready,
    input  in_ready, out_valid, f_out
  );
endinterface

// File: rtl/sbox_lut.sv
// -----------------------------------------------------------------------------
// sbox_lut: one DES S-box as a combinational table lookup.
//   IDX     : S-box number, 1..8
//   i_chunk : 6-bit input; bit 5 is the first DES bit (b0)
//   o_val   : 4-bit substitution result
// -----------------------------------------------------------------------------
module sbox_lut
  import des_pkg::*;
#(
  parameter int IDX = 1
) (
  input  logic [SBOX_IN_W-1:0]  i_chunk,
  output logic [SBOX_OUT_W-1:0] o_val
);

  logic [1:0] w_row;
  logic [3:0] w_col;

  // The row is taken from the outer bits {b0,b5}. The column is taken from the inner bits b1..b4.
  assign w_row = {i_chunk[5], i_chunk[0]};
  assign w_col = i_chunk[4:1];
  assign o_val = SBOX[IDX-1][w_row][w_col];

endmodule

// File: rtl/sbox_stage.sv
// -----------------------------------------------------------------------------
// sbox_stage: DES f-function back end. It performs key mixing, then S-boxes, then P.
// It is a two-stage valid/ready pipeline.
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : sbox_stage_if.slave
//         in_valid/in_ready/exp_data/subkey in, out_valid/out_ready/f_out out
// Stage 1 holds mix = exp_data ^ subkey. Stage 2 holds f_out.
// Build option SBOX_PERM_EN:
//   defined   : f_out = P(S(mix))
//   undefined : f_out = S(mix), and P is applied by the round controller
// -----------------------------------------------------------------------------
module sbox_stage
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  sbox_stage_if.slave bus
);

  logic  r_s1_valid;
  exp_t  r_s1_mix;
  logic  r_s2_valid;
  half_t r_f_out;

  logic  w_s2_advance;
  logic  w_in_ready;
  logic  w_in_xfer;
  half_t w_s_raw;
  half_t w_f_next;

  // Stage 2 can take a word if it is empty or if its word leaves this cycle.
  // Stage 1 can take a word on the same terms, so it refills while it drains.
  assign w_s2_advance = !r_s2_valid || bus.out_ready;
  assign w_in_ready   = !rst && (!r_s1_valid || w_s2_advance);
  assign w_in_xfer    = bus.in_valid && w_in_ready;

  // S1 takes the MSB chunk and drives the MSB nibble.
  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    sbox_lut #(.IDX(g + 1)) u_lut (
      .i_chunk (r_s1_mix[47 - SBOX_IN_W*g -: SBOX_IN_W]),
      .o_val   (w_s_raw[31 - SBOX_OUT_W*g -: SBOX_OUT_W])
    );
  end

`ifdef SBOX_PERM_EN
  assign w_f_next = p_permute(w_s_raw);
`else
  assign w_f_next = w_s_raw;
`endif

  // Stage 1: the key-mixed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mix   <= 48'h0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_mix   <= bus.exp_data ^ bus.subkey;
    end else if (r_s1_valid && w_s2_advance) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: the f-function result. It holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_f_out    <= 32'h0;
    end else if (w_s2_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_f_out <= w_f_next;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.f_out     = r_f_out;

endmodule

// File: tb/tb_sbox_stage.sv
// -----------------------------------------------------------------------------
// tb_sbox_stage: directed self-checking bench for sbox_stage.
// -----------------------------------------------------------------------------
module tb_sbox_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sbox_stage_if bus();

  sbox_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // All-zero mix substitutes to these row-0 column-0 values.
  localparam logic [31:0] ZERO_RAW = 32'hEFA72C4D;

`ifdef SBOX_PERM_EN
  localparam int P_TB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  function automatic logic [31:0] p_tb(input logic [31:0] din);
    logic [31:0] d;
    d = 32'h0;
    for (int j = 0; j < 32; j++) d[31-j] = din[32 - P_TB[j]];
    return d;
  endfunction
`endif

  function automatic logic [31:0] expect_f(input logic [31:0] raw);
`ifdef SBOX_PERM_EN
    return p_tb(raw);
`else
    return raw;
`endif
  endfunction

  // The four corner patterns are row0/col0, row0/col15, row3/col0 and row3/col15.
  function automatic logic [5:0] pat(input int k);
    case (k)
      0:       return 6'b000000;
      1:       return 6'b011110;
      2:       return 6'b100001;
      default: return 6'b111111;
    endcase
  endfunction

  // These are the corner entries of each DES S-box, in pattern order.
  function automatic logic [31:0] corner_raw(input int box, input int k);
    logic [15:0] c;
    logic [31:0] r;
    case (box)
      1:       c = 16'hE7FD;
      2:       c = 16'hFAD9;
      3:       c = 16'hA81C;
      4:       c = 16'h7F3E;
      5:       c = 16'h29B3;
      6:       c = 16'hCB4D;
      7:       c = 16'h416C;
      default: c = 16'hD72B;
    endcase
    r = ZERO_RAW;
    r[31 - 4*(box-1) -: 4] = c[15 - 4*k -: 4];
    return r;
  endfunction

  function automatic logic [47:0] mix_of(input int box, input int k);
    logic [47:0] m;
    m = 48'h0;
    m[47 - 6*(box-1) -: 6] = pat(k);
    return m;
  endfunction

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.exp_data = 48'h0;
    bus.subkey   = 48'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_total++;
    if (bus.f_out !== 32'h0) begin n_bad++; $display("FAIL reset_f_out: got %h want 00000000", bus.f_out); end
    n_total++;
    if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_held: got %b want 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_rel: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_des_vector();
    logic [31:0] want;
`ifdef SBOX_PERM_EN
    want = 32'h234AA9BB;
`else
    want = 32'h5C82B597;
`endif
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.exp_data  = 48'h7A15557A1555;
    bus.subkey    = 48'h1B02EFFC7072;
    @(posedge clk); #1;
    idle();
    n_total++;
    if (u_dut.r_s1_mix !== 48'h6117BA866527) begin n_bad++; $display("FAIL des_mix: got %h want 6117ba866527", u_dut.r_s1_mix); end
    n_total++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL des_early_valid: got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.f_out !== want) begin
      n_bad++; $display("FAIL des_f_out: got v=%b %h want v=1 %h", bus.out_valid, bus.f_out, want);
    end
    @(posedge clk); #1;
    n_total++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL des_single: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_zero();
    logic [31:0] want;
    want = expect_f(ZERO_RAW);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.exp_data  = 48'h0;
    bus.subkey    = 48'h0;
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.f_out !== want) begin
      n_bad++; $display("FAIL zero_f_out: got v=%b %h want v=1 %h", bus.out_valid, bus.f_out, want);
    end
  endtask

  task automatic test_boundary();
    logic [47:0] key;
    logic [31:0] want;
    bus.out_ready = 1'b1;
    for (int box = 1; box <= 8; box++) begin
      for (int k = 0; k < 4; k++) begin
        key  = 48'hA5C3_5A3C_0FF0 ^ {8{6'(box*4 + k)}};
        want = expect_f(corner_raw(box, k));
        bus.in_valid = 1'b1;
        bus.subkey   = key;
        bus.exp_data = mix_of(box, k) ^ key;
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.f_out !== want) begin
          n_bad++; $display("FAIL boundary_s%0d_p%0d: got v=%b %h want v=1 %h", box, k, bus.out_valid, bus.f_out, want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] w_exp [10];
    logic [47:0] w_key [10];
    logic [31:0] w_f   [10];
    logic        want_v;
    for (int w = 0; w < 10; w++) begin
      w_key[w] = 48'h0F0F_3C3C_9999 + 48'(w * 977);
      w_exp[w] = mix_of((w % 8) + 1, (w * 3) % 4) ^ w_key[w];
      w_f[w]   = expect_f(corner_raw((w % 8) + 1, (w * 3) % 4));
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 10) begin
        bus.in_valid = 1'b1;
        bus.exp_data = w_exp[c];
        bus.subkey   = w_key[c];
      end else begin
        idle();
      end
      #1;
      n_total++;
      if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready_c%0d: got %b want 1", c, bus.in_ready); end
      @(posedge clk); #1;
      want_v = (c >= 1 && c <= 10);
      n_total++;
      if (bus.out_valid !== want_v) begin
        n_bad++; $display("FAIL b2b_out_valid_c%0d: got %b want %b", c, bus.out_valid, want_v);
      end else if (want_v) begin
        n_total++;
        if (bus.f_out !== w_f[c-1]) begin
          n_bad++; $display("FAIL b2b_data_w%0d: got %h want %h", c - 1, bus.f_out, w_f[c-1]);
        end
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [47:0] w_exp [5];
    logic [47:0] w_key [5];
    logic [31:0] w_f   [5];
    int          tx;
    int          rx;
    logic        hs_in;
    logic        hs_out;
    logic [31:0] data;
    for (int w = 0; w < 5; w++) begin
      w_key[w] = 48'h1234_5678_9ABC ^ 48'(w * 48'h0101_0101_0101);
      w_exp[w] = mix_of(w + 3, w % 4) ^ w_key[w];
      w_f[w]   = expect_f(corner_raw(w + 3, w % 4));
    end
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 40 && rx < 5; cyc++) begin
      bus.out_ready = (cyc >= 5);
      if (tx < 5) begin
        bus.in_valid = 1'b1;
        bus.exp_data = w_exp[tx];
        bus.subkey   = w_key[tx];
      end else begin
        idle();
      end
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_total++;
        if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_c%0d: got %b want 0", cyc, bus.in_ready); end
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.f_out !== w_f[0]) begin
          n_bad++; $display("FAIL bp_hold_c%0d: got v=%b %h want v=1 %h", cyc, bus.out_valid, bus.f_out, w_f[0]);
        end
      end
      if (cyc == 5) begin
        n_total++;
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_dual_advance: got %b want 1", bus.in_ready); end
      end
      hs_in  = bus.in_valid && bus.in_ready;
      hs_out = bus.out_valid && bus.out_ready;
      data   = bus.f_out;
      @(posedge clk); #1;
      if (hs_in) tx++;
      if (hs_out) begin
        n_total++;
        if (data !== w_f[rx]) begin n_bad++; $display("FAIL bp_order_w%0d: got %h want %h", rx, data, w_f[rx]); end
        rx++;
      end
      if (cyc == 4) begin
        n_total++;
        if (tx !== 2) begin n_bad++; $display("FAIL bp_accepts: got %0d want 2", tx); end
      end
    end
    idle();
    n_total++;
    if (rx !== 5) begin n_bad++; $display("FAIL bp_drained: got %0d want 5", rx); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] want;
    bus.out_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      bus.in_valid = 1'b1;
      bus.exp_data = mix_of(w + 1, 3);
      bus.subkey   = 48'h0;
      @(posedge clk); #1;
    end
    idle();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_full: got v=%b rdy=%b want v=1 rdy=0", bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.f_out !== 32'h0) begin
      n_bad++; $display("FAIL mid_async_clear: got v=%b %h want v=0 00000000", bus.out_valid, bus.f_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    want = expect_f(corner_raw(2, 3));
    bus.in_valid = 1'b1;
    bus.exp_data = mix_of(2, 3) ^ 48'hFFFF_0000_FFFF;
    bus.subkey   = 48'hFFFF_0000_FFFF;
    #1;
    @(posedge clk); #1;
    idle();
    n_total++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_fresh_early: got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.f_out !== want) begin
      n_bad++; $display("FAIL mid_fresh_data: got v=%b %h want v=1 %h", bus.out_valid, bus.f_out, want);
    end
    @(posedge clk); #1;
    n_total++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_stale: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_des_vector();
    test_zero();
    test_boundary();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sbox_stage.md
Name: sbox_stage

Overview:
- Downstream neighbour of the DES expansion block inside the Feistel f-function datapath.
- Takes the 48-bit expanded R half and the 48-bit round subkey, then performs key mixing (XOR), eight 6-to-4 S-box substitutions and the P permutation.
- Produces the 32-bit f-function result for the round controller.
- Two-stage registered pipeline with valid/ready handshakes on both sides.

Parameters:
- NUM_SBOX, 8, number of S-boxes; fixed by DES, not meant to be overridden.
- SBOX_IN_W, 6, input bits per S-box.
- SBOX_OUT_W, 4, output bits per S-box.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  expanded data and subkey valid.
- in_ready  output  1  stage can accept data this cycle.
- exp_data  input  48  expansion output E(R); bit 47 is DES bit 1.
- subkey  input  48  round key K_n; same bit ordering as exp_data.
- out_valid  output  1  f_out valid.
- out_ready  input  1  consumer accepts f_out.
- f_out  output  32  f(R,K); bit 31 is DES bit 1.

Behaviour:
- Reset is asynchronous, active-high. On reset: s1_valid=0, s2_valid=0, s1_mix=48'h0, f_out=32'h0, out_valid=0. in_ready is 1 while rst is low and stage 1 is empty.
- Stage 1 registers mix = exp_data ^ subkey when in_valid && in_ready. Stage 1 is loaded on a transfer, cleared when it advances without a refill, and otherwise holds.
- Stage 2 registers f_out = P(S(mix)).
  - S-box i (i=1..8) takes mix bits [47-6(i-1) -: 6].
  - Row = {b0,b5}, column = b1..b4, using standard DES tables.
  - Results are concatenated S1 (MSBs) to S8.
- Stage 2 advance condition: s2_advance = !s2_valid || out_ready. Stage 1 moves to stage 2 when s1_valid && s2_advance.
- in_ready = !s1_valid || s2_advance, which gives full throughput: 1 word/cycle with out_ready held high.
- Latency: a transfer at cycle N gives out_valid at N+2 when there is no backpressure.
- Backpressure:
  - out_ready low with out_valid high: f_out and out_valid hold stable.
  - Stage 1 fills; in_ready drops only when both stages are full.
  - No data is dropped or duplicated.
- Simultaneous output handshake and input transfer when both stages are full: both stages advance in the same cycle.
- out_valid must never drop without an out_ready handshake.
- rst asserted mid-stream: both stages empty immediately and in-flight words are discarded. The first post-reset transfer behaves as a fresh pipeline.
- No state machine beyond the two valid bits; the pipeline is purely combinational between registers.

Optional Feature:
- SBOX_PERM_EN defined: f_out = P(S(mix)), the standard f-function.
- SBOX_PERM_EN undefined: f_out = S(mix) raw, with P applied externally by the round controller. Latency and handshake are unchanged.

Decomposition:
- Shared package des_pkg holds:
  - the SBOX table constant (8x4x16 of 4-bit values);
  - the P_TABLE constant (32 entries);
  - typedefs half_t (32b), exp_t (48b), key48_t (48b).
- One sub-module, sbox_lut: parameter IDX (1..8), input 6 bits, output 4 bits, combinational table lookup. Instantiated 8 times via generate.

Test Plan:
- Standard DES round-1 vector, out_ready=1: exp_data=48'h7A15557A1555, subkey=48'h1B02EFFC7072 -> mix 48'h6117BA866527. Two cycles later f_out=32'h234AA9BB, or 32'h5C82B597 with SBOX_PERM_EN undefined.
- Zero vector with SBOX_PERM_EN undefined: exp_data=0, subkey=0 -> f_out=32'hEFA72C4D after 2 cycles.
- Streaming: 10 back-to-back words with out_ready=1 -> in_ready stays 1 and out_valid is high on 10 consecutive cycles starting 2 cycles after the first input. Outputs are in order and match a reference model.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> after 2 accepts in_ready=0 and f_out is stable. Releasing out_ready drains the words in order with no loss.
- Reset mid-stream: assert rst with both stages full -> out_valid=0 and f_out=0 in the same cycle, before any clock edge. The next vector after deassert appears exactly 2 cycles after acceptance.
- S-box boundary rows/columns: for each S-box, mix chunks 6'b000000, 6'b011110, 6'b100001 and 6'b111111 (other chunks 0) -> each 4-bit field matches the DES table entry for row 0 col 0, row 0 col 15, row 3 col 0 and row 3 col 15.
